// File: rtl/arrow_scroller.sv
// Four-lane falling-arrow game core: spawns arrows from an LFSR, scrolls them once per
// frame tick and scores button presses against the target zone.
//
// state | meaning
// IDLE  | waiting for start, lanes frozen
// PLAY  | game running: spawn, scroll, hit/miss scoring
// OVER  | lives exhausted, waiting for start
module arrow_scroller #(
    parameter int VBP           = 31,
    parameter int VFP           = 511,
    parameter int ARROW_H       = 32,
    parameter int SPEED         = 2,
    parameter int SPAWN_PERIOD  = 45,
    parameter int TARGET_TOP    = 420,
    parameter int TARGET_BOTTOM = 460,
    parameter int LIVES_INIT    = 3
) (
    input  logic       sclk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [2:0] decode,
    output logic [9:0] d_top,
    output logic [9:0] d_bottom,
    output logic [9:0] u_top,
    output logic [9:0] u_bottom,
    output logic [9:0] l_top,
    output logic [9:0] l_bottom,
    output logic [9:0] r_top,
    output logic [9:0] r_bottom,
    output logic       d_visible,
    output logic       u_visible,
    output logic       l_visible,
    output logic       r_visible,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       hit,
    output logic       miss,
    output logic [1:0] game_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

    localparam int              CW       = $clog2(SPAWN_PERIOD);
    localparam logic [9:0]      TOP0     = 10'(VBP);
    localparam logic [9:0]      BOT0     = 10'(VBP + ARROW_H);
    localparam logic [9:0]      HEIGHT   = 10'(ARROW_H);
    localparam logic [10:0]     VFP_L    = 11'(VFP);
    localparam logic [10:0]     SPEED_L  = 11'(SPEED);
    localparam logic [9:0]      TGT_TOP  = 10'(TARGET_TOP);
    localparam logic [9:0]      TGT_BOT  = 10'(TARGET_BOTTOM);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SPAWN_PERIOD - 1);
    localparam logic [1:0]      LIVES0   = 2'(LIVES_INIT);

    state_t        state_q, state_n;
    logic [7:0]    lfsr_q, lfsr_n;
    logic [2:0]    prev_q, code;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [7:0]    score_q, score_n;
    logic [1:0]    lives_q, lives_n;
    logic          hit_q, hit_n, miss_q, miss_n;
    logic [9:0]    top_q [4];
    logic [9:0]    top_n [4];
    logic [9:0]    bot_q [4];
    logic [9:0]    bot_n [4];
    logic [3:0]    vis_q, vis_n, hit_lane;
    logic          press;
    logic [1:0]    sel;
    logic [10:0]   step;
    logic [2:0]    falls;

    // Codes 5-7 behave exactly like "no button", including for edge detection.
    assign code  = (decode > 3'd4) ? 3'd0 : decode;
    assign press = (code != 3'd0) && (prev_q == 3'd0);
    assign sel   = code[1:0] - 2'd1;

    always_comb begin
        state_n  = state_q;
        lfsr_n   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cnt_n    = cnt_q;
        score_n  = score_q;
        lives_n  = lives_q;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        top_n    = top_q;
        bot_n    = bot_q;
        vis_n    = vis_q;
        hit_lane = 4'b0;
        step     = 11'd0;
        falls    = 3'd0;

        case (state_q)
            PLAY: begin
                if (press) begin
                    if (vis_q[sel] && bot_q[sel] >= TGT_TOP && top_q[sel] <= TGT_BOT) begin
                        hit_lane[sel] = 1'b1;
                        vis_n[sel]    = 1'b0;
                        hit_n         = 1'b1;
                        if (score_q != 8'hFF) score_n = score_q + 8'd1;
                    end else begin
                        miss_n = 1'b1;
                    end
                end
                if (frame_tick) begin
                    for (int i = 0; i < 4; i++) begin
                        if (vis_q[i] && !hit_lane[i]) begin
                            step = {1'b0, top_q[i]} + SPEED_L;
                            if (step >= VFP_L) begin
                                vis_n[i] = 1'b0;
                                falls    = falls + 3'd1;
                                miss_n   = 1'b1;
                            end else begin
                                top_n[i] = step[9:0];
                                bot_n[i] = step[9:0] + HEIGHT;
                            end
                        end
                    end
                    if (falls >= {1'b0, lives_q}) lives_n = 2'd0;
                    else                          lives_n = lives_q - falls[1:0];
                    // Spawn looks at occupancy before this tick, so a lane freed now stays empty.
                    if (cnt_q == CNT_LAST) begin
                        cnt_n = '0;
                        if (!vis_q[lfsr_q[1:0]]) begin
                            top_n[lfsr_q[1:0]] = TOP0;
                            bot_n[lfsr_q[1:0]] = BOT0;
                            vis_n[lfsr_q[1:0]] = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                if (lives_n == 2'd0) begin
                    state_n = OVER;
                    vis_n   = 4'b0;
                end
            end
            default: begin
                if (start) begin
                    state_n = PLAY;
                    score_n = 8'd0;
                    lives_n = LIVES0;
                    cnt_n   = '0;
                    vis_n   = 4'b0;
                end
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (clr) begin
            state_q <= IDLE;
            lfsr_q  <= 8'hA5;
            prev_q  <= 3'd0;
            cnt_q   <= '0;
            score_q <= 8'd0;
            lives_q <= LIVES0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            vis_q   <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                top_q[i] <= TOP0;
                bot_q[i] <= BOT0;
            end
        end else begin
            state_q <= state_n;
            lfsr_q  <= lfsr_n;
            prev_q  <= code;
            cnt_q   <= cnt_n;
            score_q <= score_n;
            lives_q <= lives_n;
            hit_q   <= hit_n;
            miss_q  <= miss_n;
            vis_q   <= vis_n;
            top_q   <= top_n;
            bot_q   <= bot_n;
        end
    end

    assign d_top      = top_q[0];
    assign d_bottom   = bot_q[0];
    assign u_top      = top_q[1];
    assign u_bottom   = bot_q[1];
    assign l_top      = top_q[2];
    assign l_bottom   = bot_q[2];
    assign r_top      = top_q[3];
    assign r_bottom   = bot_q[3];
    assign d_visible  = vis_q[0];
    assign u_visible  = vis_q[1];
    assign l_visible  = vis_q[2];
    assign r_visible  = vis_q[3];
    assign score      = score_q;
    assign lives      = lives_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign game_state = state_q;
endmodule

// File: tb/tb_arrow_scroller.sv
// Bench for arrow_scroller: a lane-level game model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_arrow_scroller;
    logic       sclk = 1'b0;
    logic       clr, frame_tick, start;
    logic [2:0] decode;
    logic [9:0] d_top, d_bottom, u_top, u_bottom, l_top, l_bottom, r_top, r_bottom;
    logic       d_visible, u_visible, l_visible, r_visible;
    logic [7:0] score;
    logic [1:0] lives;
    logic       hit, miss;
    logic [1:0] game_state;

    arrow_scroller dut (
        .sclk(sclk), .clr(clr), .frame_tick(frame_tick), .start(start), .decode(decode),
        .d_top(d_top), .d_bottom(d_bottom), .u_top(u_top), .u_bottom(u_bottom),
        .l_top(l_top), .l_bottom(l_bottom), .r_top(r_top), .r_bottom(r_bottom),
        .d_visible(d_visible), .u_visible(u_visible), .l_visible(l_visible), .r_visible(r_visible),
        .score(score), .lives(lives), .hit(hit), .miss(miss), .game_state(game_state)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    int spawn_lane = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: positions as plain integers, rules applied in event order.
    int         m_state, m_score, m_lives, m_cnt, m_prev;
    int         m_top [4];
    bit         m_vis [4];
    bit         m_hit, m_miss;
    logic [7:0] m_lfsr;

    always @(posedge sclk) begin : model_blk
        int code, hit_l;
        bit pressed;
        bit was_vis [4];
        if (clr) begin
            m_state = 0; m_score = 0; m_lives = 3; m_cnt = 0; m_prev = 0;
            m_hit = 0; m_miss = 0; m_lfsr = 8'hA5;
            for (int i = 0; i < 4; i++) begin m_top[i] = 31; m_vis[i] = 0; end
        end else begin
            code    = (decode <= 3'd4) ? int'(decode) : 0;
            pressed = (code != 0) && (m_prev == 0);
            was_vis = m_vis;
            m_hit   = 0;
            m_miss  = 0;
            hit_l   = -1;
            if (m_state != 1) begin
                if (start) begin
                    m_state = 1; m_score = 0; m_lives = 3; m_cnt = 0;
                    for (int i = 0; i < 4; i++) m_vis[i] = 0;
                end
            end else begin
                if (pressed) begin
                    if (m_vis[code-1] && m_top[code-1] + 32 >= 420 && m_top[code-1] <= 460) begin
                        hit_l = code - 1;
                        m_vis[code-1] = 0;
                        m_score = (m_score < 255) ? m_score + 1 : 255;
                        m_hit = 1;
                    end else begin
                        m_miss = 1;
                    end
                end
                if (frame_tick) begin
                    for (int i = 0; i < 4; i++) begin
                        if (was_vis[i] && i != hit_l) begin
                            if (m_top[i] + 2 >= 511) begin
                                m_vis[i] = 0;
                                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                                m_miss = 1;
                            end else begin
                                m_top[i] = m_top[i] + 2;
                            end
                        end
                    end
                    if (m_cnt == 44) begin
                        m_cnt = 0;
                        if (!was_vis[m_lfsr[1:0]]) begin
                            m_top[m_lfsr[1:0]] = 31;
                            m_vis[m_lfsr[1:0]] = 1;
                        end
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                if (m_lives == 0) begin
                    m_state = 2;
                    for (int i = 0; i < 4; i++) m_vis[i] = 0;
                end
            end
            m_prev = code;
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    always @(negedge sclk) begin
        if (chk_on) begin
            int tops [4];
            int bots [4];
            int viss [4];
            tops = '{int'(d_top), int'(u_top), int'(l_top), int'(r_top)};
            bots = '{int'(d_bottom), int'(u_bottom), int'(l_bottom), int'(r_bottom)};
            viss = '{int'(d_visible), int'(u_visible), int'(l_visible), int'(r_visible)};
            chk("model_state", int'(game_state), m_state);
            chk("model_score", int'(score), m_score);
            chk("model_lives", int'(lives), m_lives);
            chk("model_hit", int'(hit), int'(m_hit));
            chk("model_miss", int'(miss), int'(m_miss));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model_vis%0d", i), viss[i], int'(m_vis[i]));
                chk($sformatf("model_top%0d", i), tops[i], m_top[i]);
                chk($sformatf("model_bot%0d", i), bots[i], m_top[i] + 32);
            end
        end
    end

    task automatic cyc(input bit ft, input bit st, input logic [2:0] dec);
        frame_tick = ft;
        start      = st;
        decode     = dec;
        @(negedge sclk);
    endtask

    // Frame tick; a spawn tick is delayed until the LFSR selects spawn_lane.
    task automatic tick(input logic [2:0] dec);
        int n;
        n = 0;
        if (m_state == 1 && m_cnt == 44) begin
            while (m_lfsr[1:0] != 2'(spawn_lane) && n < 300) begin
                cyc(0, 0, 3'd0);
                n++;
            end
            if (n >= 300) begin
                errors++; checks++;
                $display("FAIL spawn_steer: got timeout, expected lane %0d", spawn_lane);
            end
        end
        cyc(1, 0, dec);
    endtask

    task automatic frame();
        tick(3'd0);
        cyc(0, 0, 3'd0);
    endtask

    task automatic advance_to(input int lane, input int target);
        int n;
        n = 0;
        while (!(m_vis[lane] && m_top[lane] == target) && n < 1000) begin
            frame();
            n++;
        end
        if (n >= 1000) begin
            errors++; checks++;
            $display("FAIL advance_to: got timeout, expected lane %0d at top %0d", lane, target);
        end
    endtask

    initial begin
        clr = 1'b1; frame_tick = 1'b0; start = 1'b0; decode = 3'd0;
        chk_on = 1'b1;
        @(negedge sclk);
        chk("rst_state", int'(game_state), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_d_top", int'(d_top), 31);
        chk("rst_d_bottom", int'(d_bottom), 63);
        chk("rst_vis", int'({d_visible, u_visible, l_visible, r_visible}), 0);
        clr = 1'b0;

        cyc(0, 1, 3'd0);
        chk("start_state", int'(game_state), 1);
        cyc(0, 0, 3'd0);
        spawn_lane = 0;
        repeat (44) frame();
        chk("pre_spawn_dvis", int'(d_visible), 0);
        frame();
        chk("spawn_dvis", int'(d_visible), 1);
        chk("spawn_dtop", int'(d_top), 31);
        chk("spawn_dbot", int'(d_bottom), 63);
        frame();
        chk("scroll_dtop", int'(d_top), 33);
        chk("scroll_dbot", int'(d_bottom), 65);

        cyc(0, 0, 3'd2);
        chk("empty_press_miss", int'(miss), 1);
        chk("empty_press_lives", int'(lives), 3);
        cyc(0, 0, 3'd0);
        chk("miss_pulse_end", int'(miss), 0);
        cyc(0, 0, 3'd5);
        chk("code5_ignored", int'(miss), 0);
        cyc(0, 0, 3'd0);

        advance_to(0, 387);
        cyc(0, 0, 3'd1);
        chk("zone_above_miss", int'(miss), 1);
        chk("zone_above_dvis", int'(d_visible), 1);
        cyc(0, 0, 3'd0);
        frame();
        chk("d_at_389", int'(d_top), 389);
        cyc(0, 0, 3'd1);
        chk("hit389_hit", int'(hit), 1);
        chk("hit389_score", int'(score), 1);
        chk("hit389_dvis", int'(d_visible), 0);
        repeat (10) begin
            cyc(0, 0, 3'd1);
            chk("hold_no_hit", int'(hit), 0);
            chk("hold_no_miss", int'(miss), 0);
        end
        cyc(0, 0, 3'd0);

        advance_to(0, 419);
        tick(3'd1);
        chk("same_cycle_hit", int'(hit), 1);
        chk("same_cycle_score", int'(score), 2);
        chk("same_cycle_dvis", int'(d_visible), 0);
        chk("same_cycle_dtop", int'(d_top), 419);
        cyc(0, 0, 3'd0);

        advance_to(0, 459);
        cyc(0, 0, 3'd1);
        chk("hit459_hit", int'(hit), 1);
        chk("hit459_score", int'(score), 3);
        cyc(0, 0, 3'd0);

        advance_to(0, 461);
        cyc(0, 0, 3'd1);
        chk("zone_below_miss", int'(miss), 1);
        chk("zone_below_hit", int'(hit), 0);
        chk("zone_below_score", int'(score), 3);
        cyc(0, 0, 3'd0);
        advance_to(0, 509);
        tick(3'd0);
        chk("fall1_dvis", int'(d_visible), 0);
        chk("fall1_miss", int'(miss), 1);
        chk("fall1_lives", int'(lives), 2);
        cyc(0, 0, 3'd0);

        advance_to(0, 509);
        tick(3'd0);
        chk("fall2_lives", int'(lives), 1);
        cyc(0, 0, 3'd0);

        advance_to(0, 101);
        spawn_lane = 1;
        advance_to(0, 509);
        chk("pre_over_uvis", int'(u_visible), 1);
        tick(3'd0);
        chk("over_state", int'(game_state), 2);
        chk("over_lives", int'(lives), 0);
        chk("over_vis", int'({d_visible, u_visible, l_visible, r_visible}), 0);
        chk("over_miss", int'(miss), 1);
        cyc(0, 0, 3'd0);
        cyc(0, 0, 3'd3);
        chk("over_press_ignored", int'(miss), 0);
        cyc(0, 0, 3'd0);

        cyc(0, 1, 3'd0);
        chk("restart_state", int'(game_state), 1);
        chk("restart_lives", int'(lives), 3);
        chk("restart_score", int'(score), 0);
        cyc(0, 0, 3'd0);

        spawn_lane = 0;
        advance_to(0, 201);
        clr = 1'b1;
        cyc(0, 0, 3'd0);
        clr = 1'b0;
        chk("midrst_state", int'(game_state), 0);
        chk("midrst_score", int'(score), 0);
        chk("midrst_lives", int'(lives), 3);
        chk("midrst_vis", int'({d_visible, u_visible, l_visible, r_visible}), 0);
        chk("midrst_dtop", int'(d_top), 31);
        frame();
        chk("idle_no_scroll", int'(d_top), 31);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arrow_scroller.md
Name: arrow_scroller

Overview:
Upstream stage of the per-lane arrow renderers. Owns the game state for four lanes (down, up, left, right): spawns falling arrows pseudo-randomly, scrolls them once per video frame, and checks button presses against a target zone. Drives the top/bottom/visible inputs of the renderer stage, plus score, lives and event pulses.

Parameters:
VBP, 31, first visible line; spawn top position.
VFP, 511, first line past the visible area; an arrow whose top reaches it has fallen off.
ARROW_H, 32, arrow height in lines; bottom = top + ARROW_H.
SPEED, 2, lines moved per frame tick.
SPAWN_PERIOD, 45, frame ticks between spawn attempts.
TARGET_TOP, 420, first line of the hit zone.
TARGET_BOTTOM, 460, last line of the hit zone.
LIVES_INIT, 3, lives at game start.

Ports:
sclk  in  1  system clock.
clr  in  1  reset; synchronous, active-high.
frame_tick  in  1  one-cycle pulse per frame, sourced from vsync.
start  in  1  level; starts the game from IDLE or OVER.
decode  in  3  debounced button code: 0 none, 1 down, 2 up, 3 left, 4 right, 5-7 ignored.
d_top, d_bottom, u_top, u_bottom, l_top, l_bottom, r_top, r_bottom  out  10 each  arrow vertical extents.
d_visible, u_visible, l_visible, r_visible  out  1 each  arrow present in lane.
score  out  8  hit count, saturating at 255.
lives  out  2  remaining lives.
hit  out  1  one-cycle pulse on a successful press.
miss  out  1  one-cycle pulse on a wrong press or a fall-off.
game_state  out  2  0 IDLE, 1 PLAY, 2 OVER.

Behaviour:
- Reset, applied on any sclk edge with clr=1, including mid-game:
  - State goes to IDLE.
  - All tops = VBP, bottoms = VBP+ARROW_H, visible flags = 0.
  - score = 0, lives = LIVES_INIT, hit = 0, miss = 0.
  - Spawn counter = 0; LFSR = 8'hA5.
- FSM:
  - IDLE -> PLAY on start=1. On entry, score, lives, spawn counter and visible flags are cleared/reloaded.
  - PLAY -> OVER in the cycle lives reaches 0; all visible flags clear that cycle.
  - OVER -> PLAY on start=1, with the same reinitialisation as from IDLE.
  - PLAY has no exit on start.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every cycle in all states; never reaches zero.
- Press detection:
  - A press is decode going from 0 to 1..4 (registered previous value). Holding the button produces one press.
  - Codes 5-7 are treated as 0.
- Hit check (PLAY only), using positions before any same-cycle scroll:
  - Press in lane L with L visible and bottom >= TARGET_TOP and top <= TARGET_BOTTOM: clear L visible, score += 1 (saturating), hit = 1 next cycle.
  - Otherwise: miss = 1 next cycle, no life lost.
- Scroll, on frame_tick in PLAY, for each visible lane not hit this cycle:
  - next = top + SPEED, computed in 11 bits.
  - If next >= VFP: clear visible, lives -= 1 (saturating at 0, one per lane falling off this tick), miss = 1.
  - Otherwise top = next, bottom = next + ARROW_H.
- Spawn, on frame_tick in PLAY:
  - Spawn counter increments; when it equals SPAWN_PERIOD-1 it wraps to 0 and a spawn attempt occurs.
  - Lane = LFSR[1:0] (0 d, 1 u, 2 l, 3 r).
  - If that lane's visible flag was 0 before this tick: top = VBP, bottom = VBP+ARROW_H, visible = 1.
  - Otherwise the spawn is skipped. A lane freed by fall-off or hit on the same tick stays empty.
- Outputs are registered; extents and visible flags change one cycle after frame_tick.
- hit and miss can both be 1 in the same cycle (hit press plus a different lane falling off).

Test Plan:
- Reset mid-PLAY with score=7 and lives=1 -> next cycle: state 0, score 0, lives 3, all visible flags 0, d_top 31.
- start=1, then 45 frame_ticks with LFSR forced so lane=0 -> d_visible=1, d_top=31, d_bottom=63. One more tick -> d_top=33.
- Down arrow at top=420, press decode=1 -> hit pulse, score=1, d_visible=0. Holding decode=1 for 10 cycles gives no further events.
- Press decode=2 with u_visible=0 -> miss pulse, lives unchanged at 3.
- Down arrow at top=509, frame_tick -> d_visible=0, lives 3->2, miss pulse. Three fall-offs -> game_state=2, all visible flags 0; start=1 -> PLAY with lives=3, score=0.
- Press and frame_tick in the same cycle with arrow top=419 (bottom 451) -> evaluated as a hit on pre-move position: score increments, arrow does not move.
